// File: rtl/adc_lane_align_pkg.sv
// Shared types and default constants for the ADC lane alignment block.
package adc_lane_align_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DLY_RST = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CHECK   = 3'd3,
    ST_STEP    = 3'd4,
    ST_CENTER  = 3'd5,
    ST_LOCKED  = 3'd6,
    ST_FAIL    = 3'd7
  } state_t;

  localparam int DEF_ADC_DATA_WIDTH    = 8;
  localparam int DEF_PARALLEL_PATH_NUM = 2;
  localparam int DEF_SETTLE_CYCLES     = 16;
  localparam int DEF_CHECK_LEN         = 64;
  localparam int DEF_TAP_MAX           = 31;
  localparam int TAP_WIDTH             = 5;

endpackage

// File: rtl/adc_pattern_check.sv
// Training-pattern window checker: compares CHECK_LEN samples against the
// pattern in straight and lane-reversed order and reports the verdict.
module adc_pattern_check
  import adc_lane_align_pkg::*;
#(
  parameter int ADC_DATA_WIDTH    = DEF_ADC_DATA_WIDTH,
  parameter int PARALLEL_PATH_NUM = DEF_PARALLEL_PATH_NUM,
  parameter logic [PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] TRAIN_PATTERN = 16'hAA55,
  parameter int CHECK_LEN         = DEF_CHECK_LEN
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst_n,
  input  logic                                        i_clr,
  input  logic                                        i_en,
  input  logic [PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] i_data,
  output logic                                        o_done,
  output logic                                        o_good,
  output logic                                        o_swap
);

  localparam int W  = PARALLEL_PATH_NUM * ADC_DATA_WIDTH;
  localparam int CW = $clog2(CHECK_LEN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CHECK_LEN - 1);

  logic [W-1:0]  w_patSwap;
  logic          w_matchStraight;
  logic          w_matchSwap;
  logic [CW-1:0] r_cnt;
  logic          r_straightOk;
  logic          r_swapOk;
  logic          r_done;

  for (genvar g = 0; g < PARALLEL_PATH_NUM; g++) begin : g_patSwap
    assign w_patSwap[g*ADC_DATA_WIDTH +: ADC_DATA_WIDTH] =
      TRAIN_PATTERN[(PARALLEL_PATH_NUM-1-g)*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
  end

  assign w_matchStraight = (i_data == TRAIN_PATTERN);
  assign w_matchSwap     = (i_data == w_patSwap);

  // Each orientation flag survives only if every sample in the window matched it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= '0;
      r_straightOk <= 1'b0;
      r_swapOk     <= 1'b0;
      r_done       <= 1'b0;
    end else if (i_clr) begin
      r_cnt        <= '0;
      r_straightOk <= 1'b1;
      r_swapOk     <= 1'b1;
      r_done       <= 1'b0;
    end else if (i_en && !r_done) begin
      r_straightOk <= r_straightOk & w_matchStraight;
      r_swapOk     <= r_swapOk & w_matchSwap;
      if (r_cnt == CNT_LAST) begin
        r_done <= 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_done = r_done;
  assign o_good = r_done & (r_straightOk | r_swapOk);
  assign o_swap = r_done & ~r_straightOk & r_swapOk;

endmodule

// File: rtl/adc_lane_align.sv
// ADC lane alignment: sweeps the IODELAY taps, finds the window in which the
// training pattern is seen, centres the tap in it and fixes lane order.
module adc_lane_align
  import adc_lane_align_pkg::*;
#(
  parameter int ADC_DATA_WIDTH    = DEF_ADC_DATA_WIDTH,
  parameter int PARALLEL_PATH_NUM = DEF_PARALLEL_PATH_NUM,
  parameter logic [PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] TRAIN_PATTERN = 16'hAA55,
  parameter int SETTLE_CYCLES     = DEF_SETTLE_CYCLES,
  parameter int CHECK_LEN         = DEF_CHECK_LEN,
  parameter int TAP_MAX           = DEF_TAP_MAX
) (
  input  logic                                        adc_clk_bufr,
  input  logic                                        rst_n,
  input  logic [PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] adc_parrel_i,
  input  logic                                        train_start,
  output logic [PARALLEL_PATH_NUM*ADC_DATA_WIDTH-1:0] adc_data_o,
  output logic                                        data_valid,
  output logic                                        align_locked,
  output logic                                        align_fail,
  output logic                                        lane_swap,
  output logic [TAP_WIDTH-1:0]                        tap_value,
  output logic                                        idelay_rst,
  output logic                                        idelay_ce,
  output logic                                        idelay_inc
);

  localparam int W  = PARALLEL_PATH_NUM * ADC_DATA_WIDTH;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]        SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TAP_WIDTH-1:0] TAP_LAST    = TAP_WIDTH'(TAP_MAX);

  state_t               r_state;
  state_t               w_stateNext;
  logic [TAP_WIDTH-1:0] r_tap;
  logic [TAP_WIDTH-1:0] r_firstGood;
  logic [TAP_WIDTH-1:0] r_lastGood;
  logic [TAP_WIDTH-1:0] r_target;
  logic                 r_seenGood;
  logic                 r_laneSwap;
  logic                 r_ctrRstDone;
  logic                 r_ctrToggle;
  logic [SW-1:0]        r_settleCnt;
  logic [W-1:0]         r_data;

  logic [W-1:0]         w_revData;
  logic                 w_settleDone;
  logic                 w_chkClr;
  logic                 w_chkEn;
  logic                 w_chkDone;
  logic                 w_chkGood;
  logic                 w_chkSwap;
  logic                 w_sweepEnd;
  logic                 w_atTarget;
  logic                 w_ctrStep;
  logic [TAP_WIDTH-1:0] w_firstEff;
  logic [TAP_WIDTH-1:0] w_lastEff;
  logic [TAP_WIDTH:0]   w_sum;

  for (genvar g = 0; g < PARALLEL_PATH_NUM; g++) begin : g_rev
    assign w_revData[g*ADC_DATA_WIDTH +: ADC_DATA_WIDTH] =
      adc_parrel_i[(PARALLEL_PATH_NUM-1-g)*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
  end

  adc_pattern_check #(
    .ADC_DATA_WIDTH   (ADC_DATA_WIDTH),
    .PARALLEL_PATH_NUM(PARALLEL_PATH_NUM),
    .TRAIN_PATTERN    (TRAIN_PATTERN),
    .CHECK_LEN        (CHECK_LEN)
  ) u_check (
    .i_clk  (adc_clk_bufr),
    .i_rst_n(rst_n),
    .i_clr  (w_chkClr),
    .i_en   (w_chkEn),
    .i_data (adc_parrel_i),
    .o_done (w_chkDone),
    .o_good (w_chkGood),
    .o_swap (w_chkSwap)
  );

  assign w_settleDone = (r_settleCnt == SETTLE_LAST);
  assign w_chkClr     = (r_state == ST_SETTLE) && w_settleDone;
  assign w_chkEn      = (r_state == ST_CHECK);

  // The window bounds must include the tap being judged right now.
  assign w_firstEff = (w_chkGood && !r_seenGood) ? r_tap : r_firstGood;
  assign w_lastEff  = w_chkGood ? r_tap : r_lastGood;
  assign w_sum      = {1'b0, w_firstEff} + {1'b0, w_lastEff};
  assign w_sweepEnd = (!w_chkGood && r_seenGood) || (r_tap == TAP_LAST);
  assign w_atTarget = (r_tap == r_target);
  assign w_ctrStep  = r_ctrRstDone && !w_atTarget && r_ctrToggle;

  always_ff @(posedge adc_clk_bufr or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext  = r_state;
    idelay_rst   = 1'b0;
    idelay_ce    = 1'b0;
    idelay_inc   = 1'b0;
    align_locked = 1'b0;
    align_fail   = 1'b0;
    data_valid   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (train_start) w_stateNext = ST_DLY_RST;
      end
      ST_DLY_RST: begin
        idelay_rst  = 1'b1;
        w_stateNext = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (w_settleDone) w_stateNext = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_chkDone) w_stateNext = ST_STEP;
      end
      ST_STEP: begin
        if (w_sweepEnd) begin
          w_stateNext = (r_seenGood || w_chkGood) ? ST_CENTER : ST_FAIL;
        end else begin
          idelay_ce   = 1'b1;
          idelay_inc  = 1'b1;
          w_stateNext = ST_SETTLE;
        end
      end
      ST_CENTER: begin
        idelay_rst = !r_ctrRstDone;
        idelay_ce  = w_ctrStep;
        idelay_inc = w_ctrStep;
        if (r_ctrRstDone && w_atTarget && w_settleDone) w_stateNext = ST_LOCKED;
      end
      ST_LOCKED: begin
        align_locked = 1'b1;
        data_valid   = 1'b1;
        if (train_start) w_stateNext = ST_DLY_RST;
      end
      ST_FAIL: begin
        align_fail = 1'b1;
        if (train_start) w_stateNext = ST_DLY_RST;
      end
      default: w_stateNext = ST_IDLE;
    endcase
  end

  // Sweep bookkeeping; CENTER replays the taps from zero with a gap between pulses.
  always_ff @(posedge adc_clk_bufr or negedge rst_n) begin
    if (!rst_n) begin
      r_tap        <= '0;
      r_firstGood  <= '0;
      r_lastGood   <= '0;
      r_target     <= '0;
      r_seenGood   <= 1'b0;
      r_laneSwap   <= 1'b0;
      r_ctrRstDone <= 1'b0;
      r_ctrToggle  <= 1'b0;
      r_settleCnt  <= '0;
    end else begin
      case (r_state)
        ST_DLY_RST: begin
          r_tap       <= '0;
          r_firstGood <= '0;
          r_lastGood  <= '0;
          r_seenGood  <= 1'b0;
          r_laneSwap  <= 1'b0;
          r_settleCnt <= '0;
        end
        ST_SETTLE: begin
          r_settleCnt <= w_settleDone ? '0 : r_settleCnt + 1'b1;
        end
        ST_STEP: begin
          if (w_chkGood) begin
            if (!r_seenGood) begin
              r_firstGood <= r_tap;
              r_seenGood  <= 1'b1;
            end
            r_lastGood <= r_tap;
            r_laneSwap <= w_chkSwap;
          end
          r_settleCnt <= '0;
          if (w_sweepEnd) begin
            r_target     <= TAP_WIDTH'(w_sum >> 1);
            r_ctrRstDone <= 1'b0;
            r_ctrToggle  <= 1'b0;
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        ST_CENTER: begin
          if (!r_ctrRstDone) begin
            r_ctrRstDone <= 1'b1;
            r_ctrToggle  <= 1'b0;
            r_tap        <= '0;
          end else if (!w_atTarget) begin
            r_ctrToggle <= ~r_ctrToggle;
            if (r_ctrToggle) r_tap <= r_tap + 1'b1;
          end else begin
            r_settleCnt <= r_settleCnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge adc_clk_bufr or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else begin
      r_data <= r_laneSwap ? w_revData : adc_parrel_i;
    end
  end

  assign adc_data_o = r_data;
  assign lane_swap  = r_laneSwap;
  assign tap_value  = r_tap;

endmodule

// File: tb/tb_adc_lane_align.sv
// Directed bench for adc_lane_align: an IODELAY tap model picks the word
// presented at each tap, and sweep results are compared to hand-derived values.
module tb_adc_lane_align;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] adc_parrel_i;
  logic        train_start;
  logic [15:0] adc_data_o;
  logic        data_valid, align_locked, align_fail, lane_swap;
  logic [4:0]  tap_value;
  logic        idelay_rst, idelay_ce, idelay_inc;

  always #5 clk = ~clk;

  adc_lane_align dut (
    .adc_clk_bufr(clk),
    .rst_n       (rst_n),
    .adc_parrel_i(adc_parrel_i),
    .train_start (train_start),
    .adc_data_o  (adc_data_o),
    .data_valid  (data_valid),
    .align_locked(align_locked),
    .align_fail  (align_fail),
    .lane_swap   (lane_swap),
    .tap_value   (tap_value),
    .idelay_rst  (idelay_rst),
    .idelay_ce   (idelay_ce),
    .idelay_inc  (idelay_inc)
  );

  typedef struct {
    string       name;
    int          lo, hi, alt;
    logic        altEn;
    logic [15:0] word;
    logic        expLocked;
    int          expTap;
    logic        expSwap;
    int          expSweep, expCenter;
    logic [15:0] probeIn, probeOut;
  } vec_t;

  vec_t vecs[6];

  int assertCount = 0;
  int failCount   = 0;
  int tbTap = 0, rstCount = 0, ceCount = 0, sweepCe = 0;
  int curLo = 1, curHi = 0, curAlt = 0;
  logic curAltEn = 1'b0, altPhase = 1'b0;
  logic probeActive = 1'b0;
  logic [15:0] probeWord = 16'h0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Pulses are sampled mid-cycle; the new word is driven just after the edge.
  task automatic tick();
    @(negedge clk);
    if (idelay_rst) begin
      tbTap = 0;
      rstCount++;
      if (rstCount == 2) sweepCe = ceCount;
    end else if (idelay_ce && idelay_inc) begin
      tbTap++;
      ceCount++;
    end
    @(posedge clk);
    #1;
    if (probeActive) adc_parrel_i = probeWord;
    else if (curAltEn && tbTap == curAlt) begin
      altPhase = ~altPhase;
      adc_parrel_i = altPhase ? 16'hAA55 : 16'h55AA;
    end else if (tbTap >= curLo && tbTap <= curHi) adc_parrel_i = curWord();
    else adc_parrel_i = 16'h1234;
  endtask

  logic [15:0] scenWord = 16'hAA55;
  function automatic logic [15:0] curWord();
    return scenWord;
  endfunction

  task automatic resetCounters();
    rstCount = 0;
    ceCount  = 0;
    sweepCe  = 0;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    resetCounters();
  endtask

  task automatic applyStimulus();
    train_start = 1'b1;
    tick();
    train_start = 1'b0;
  endtask

  task automatic waitDone(input string name);
    int n = 0;
    while (!(align_locked || align_fail) && n < 8000) begin
      tick();
      n++;
    end
    checkOutput({name, "_done_in_budget"}, 32'(align_locked | align_fail), 32'd1);
  endtask

  function automatic int sweepPulses();
    return (rstCount >= 2) ? sweepCe : ceCount;
  endfunction

  initial begin
    vecs[0] = '{"straight_10_18", 10, 18, 0, 1'b0, 16'hAA55, 1'b1, 14, 1'b0, 19, 14, 16'hA1B2, 16'hA1B2};
    vecs[1] = '{"swapped_4_8",     4,  8, 0, 1'b0, 16'h55AA, 1'b1,  6, 1'b1,  9,  6, 16'h55AA, 16'hAA55};
    vecs[2] = '{"never",           1,  0, 0, 1'b0, 16'hAA55, 1'b0, 31, 1'b0, 31,  0, 16'hC3D4, 16'hC3D4};
    vecs[3] = '{"mixed_tap12",    10, 14, 12, 1'b1, 16'hAA55, 1'b1, 10, 1'b0, 12, 10, 16'h0F1E, 16'h0F1E};
    vecs[4] = '{"tap0_only",       0,  0, 0, 1'b0, 16'hAA55, 1'b1,  0, 1'b0,  1,  0, 16'h1234, 16'h1234};
    vecs[5] = '{"swapped_29_31",  29, 31, 0, 1'b0, 16'h55AA, 1'b1, 30, 1'b1, 31, 30, 16'h1234, 16'h3412};

    rst_n = 1'b0;
    train_start = 1'b0;
    adc_parrel_i = 16'h0;
    #2;
    checkOutput("reset_tap", 32'(tap_value), 32'd0);
    checkOutput("reset_flags", 32'({align_locked, align_fail, data_valid, lane_swap}), 32'd0);
    checkOutput("reset_idelay", 32'({idelay_rst, idelay_ce, idelay_inc}), 32'd0);
    checkOutput("reset_data", 32'(adc_data_o), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    checkOutput("no_pulse_after_release", 32'({idelay_rst, idelay_ce, idelay_inc}), 32'd0);

    for (int i = 0; i < 6; i++) begin
      doReset();
      curLo = vecs[i].lo;
      curHi = vecs[i].hi;
      curAlt = vecs[i].alt;
      curAltEn = vecs[i].altEn;
      scenWord = vecs[i].word;
      altPhase = 1'b0;
      applyStimulus();
      waitDone(vecs[i].name);
      checkOutput({vecs[i].name, "_locked"}, 32'(align_locked), 32'(vecs[i].expLocked));
      checkOutput({vecs[i].name, "_fail"}, 32'(align_fail), 32'(!vecs[i].expLocked));
      checkOutput({vecs[i].name, "_valid"}, 32'(data_valid), 32'(vecs[i].expLocked));
      checkOutput({vecs[i].name, "_tap"}, 32'(tap_value), 32'(vecs[i].expTap));
      checkOutput({vecs[i].name, "_swap"}, 32'(lane_swap), 32'(vecs[i].expSwap));
      checkOutput({vecs[i].name, "_sweep_pulses"}, 32'(sweepPulses()), 32'(vecs[i].expSweep));
      checkOutput({vecs[i].name, "_center_pulses"}, 32'(ceCount - sweepPulses()), 32'(vecs[i].expCenter));
      probeWord = vecs[i].probeIn;
      probeActive = 1'b1;
      tick();
      tick();
      checkOutput({vecs[i].name, "_data_out"}, 32'(adc_data_o), 32'(vecs[i].probeOut));
      probeActive = 1'b0;
    end

    // Reset in the middle of the CHECK window at tap 7, then retrain from scratch.
    doReset();
    curLo = 10; curHi = 18; curAltEn = 1'b0; scenWord = 16'hAA55;
    applyStimulus();
    begin
      int n = 0;
      while (tbTap != 7 && n < 2000) begin
        tick();
        n++;
      end
    end
    repeat (36) tick();
    checkOutput("midcheck_tap_before_reset", 32'(tap_value), 32'd7);
    rst_n = 1'b0;
    #1;
    checkOutput("midcheck_reset_tap", 32'(tap_value), 32'd0);
    checkOutput("midcheck_reset_data", 32'(adc_data_o), 32'd0);
    checkOutput("midcheck_reset_flags",
                32'({align_locked, align_fail, data_valid, lane_swap, idelay_rst, idelay_ce, idelay_inc}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    #3;
    checkOutput("midcheck_no_pulse_after_release", 32'({idelay_rst, idelay_ce, idelay_inc}), 32'd0);
    tick();
    resetCounters();
    applyStimulus();
    waitDone("midcheck_restart");
    checkOutput("midcheck_restart_locked", 32'(align_locked), 32'd1);
    checkOutput("midcheck_restart_tap", 32'(tap_value), 32'd14);
    checkOutput("midcheck_restart_sweep", 32'(sweepPulses()), 32'd19);

    // Retrain from LOCKED, with a stray train_start while settling.
    resetCounters();
    applyStimulus();
    repeat (3) tick();
    checkOutput("retrain_rst_pulse", 32'(rstCount), 32'd1);
    checkOutput("retrain_unlocked", 32'(align_locked), 32'd0);
    applyStimulus();
    waitDone("retrain");
    checkOutput("retrain_locked", 32'(align_locked), 32'd1);
    checkOutput("retrain_tap", 32'(tap_value), 32'd14);
    checkOutput("retrain_swap", 32'(lane_swap), 32'd0);
    checkOutput("retrain_rst_total", 32'(rstCount), 32'd2);
    checkOutput("retrain_sweep", 32'(sweepPulses()), 32'd19);
    checkOutput("retrain_center", 32'(ceCount - sweepPulses()), 32'd14);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
